fifo_param: RTL and testbench

- Parametrised synchronous FIFO; successor to the fixed-size FIFO used in the matrix-vector datapath.
- Generalised in data width and depth. Depth is any integer ≥2, not only powers of two.
- Adds a selectable read mode (registered-read or first-word-fall-through), an occupancy count, almost-full/almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags.
- Sits between producer and consumer stages of the datapath (e.g. vector-element buffering ahead of the MAC).

---
 rtl/fifo_param.sv | 120 ++++++++++++
 tb/tb_fifo_param.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with selectable registered-read / first-word-fall-through output,
// occupancy count, almost-full/empty thresholds, synchronous flush and sticky error flags.
module fifo_param #(
    parameter int unsigned DW       = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned FWFT     = 0,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2,
    localparam int unsigned CW      = $clog2(DEPTH + 1),
    localparam int unsigned PW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic          underflow
);

    logic [DW-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          push_ok, pop_ok;

    assign count        = count_q;
    assign empty        = (count_q == '0);
    assign full         = (count_q == CW'(DEPTH));
    assign almost_full  = (count_q >= CW'(AF_LEVEL));
    assign almost_empty = (count_q <= CW'(AE_LEVEL));
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A push into a full FIFO is allowed only when a pop frees a slot in the same cycle.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            // Explicit wrap so non-power-of-two depths work.
            if (push_ok) begin
                wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (push & ~push_ok) overflow_d = 1'b1;
            if (pop & ~pop_ok) underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage has no reset; contents are only observed through valid pointers.
    always_ff @(posedge clk) begin
        if (!clr && push_ok) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign data_out = empty ? '0 : mem[rd_ptr_q];
    end else begin : g_reg
        logic [DW-1:0] data_out_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                data_out_q <= '0;
            end else if (clr) begin
                data_out_q <= '0;
            end else if (pop_ok) begin
                data_out_q <= mem[rd_ptr_q];
            end
        end

        assign data_out = data_out_q;
    end

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: three configurations driven by shared stimulus, each checked every
// cycle against a queue-based reference model.
module tb_fifo_param;

    localparam int N = 3;
    localparam int DEP [N] = '{16, 5, 5};
    localparam int FW  [N] = '{0, 0, 1};
    localparam int AFL [N] = '{14, 3, 3};
    localparam int AEL [N] = '{2, 2, 2};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] data_in = '0;

    logic [7:0] dout0, dout1, dout2;
    logic       full0, full1, full2, empty0, empty1, empty2;
    logic       af0, af1, af2, ae0, ae1, ae2;
    logic [4:0] cnt0;
    logic [2:0] cnt1, cnt2;
    logic       ovf0, ovf1, ovf2, unf0, unf1, unf2;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] mq [N][$];
    logic       movf [N];
    logic       munf [N];
    logic [7:0] mdout [N];

    always #5 clk = ~clk;

    fifo_param #(.DW(8), .DEPTH(16), .FWFT(0)) u0 (
        .clk(clk), .rst(rst), .clr(clr), .push(push), .pop(pop), .data_in(data_in),
        .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0),
        .almost_empty(ae0), .count(cnt0), .overflow(ovf0), .underflow(unf0)
    );

    fifo_param #(.DW(8), .DEPTH(5), .FWFT(0)) u1 (
        .clk(clk), .rst(rst), .clr(clr), .push(push), .pop(pop), .data_in(data_in),
        .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1),
        .almost_empty(ae1), .count(cnt1), .overflow(ovf1), .underflow(unf1)
    );

    fifo_param #(.DW(8), .DEPTH(5), .FWFT(1)) u2 (
        .clk(clk), .rst(rst), .clr(clr), .push(push), .pop(pop), .data_in(data_in),
        .data_out(dout2), .full(full2), .empty(empty2), .almost_full(af2),
        .almost_empty(ae2), .count(cnt2), .overflow(ovf2), .underflow(unf2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mq[i].delete();
            movf[i]  = 1'b0;
            munf[i]  = 1'b0;
            mdout[i] = 8'h00;
        end
    endtask

    task automatic model_clock();
        for (int i = 0; i < N; i++) begin
            bit         pok;
            bit         wok;
            logic [7:0] w;
            if (clr) begin
                mq[i].delete();
                movf[i]  = 1'b0;
                munf[i]  = 1'b0;
                mdout[i] = 8'h00;
            end else begin
                pok = pop && (mq[i].size() > 0);
                wok = push && ((mq[i].size() < DEP[i]) || pok);
                if (push && !wok) movf[i] = 1'b1;
                if (pop && !pok) munf[i] = 1'b1;
                if (pok) begin
                    w = mq[i].pop_front();
                    if (FW[i] == 0) mdout[i] = w;
                end
                if (wok) mq[i].push_back(data_in);
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            logic [31:0] o_d, o_c;
            logic        o_f, o_e, o_af, o_ae, o_ov, o_un;
            int          sz;
            logic [7:0]  e_d;
            case (i)
                0: begin
                    o_d = 32'(dout0); o_c = 32'(cnt0); o_f = full0; o_e = empty0;
                    o_af = af0; o_ae = ae0; o_ov = ovf0; o_un = unf0;
                end
                1: begin
                    o_d = 32'(dout1); o_c = 32'(cnt1); o_f = full1; o_e = empty1;
                    o_af = af1; o_ae = ae1; o_ov = ovf1; o_un = unf1;
                end
                default: begin
                    o_d = 32'(dout2); o_c = 32'(cnt2); o_f = full2; o_e = empty2;
                    o_af = af2; o_ae = ae2; o_ov = ovf2; o_un = unf2;
                end
            endcase
            sz = mq[i].size();
            if (FW[i] != 0) e_d = (sz > 0) ? mq[i][0] : 8'h00;
            else e_d = mdout[i];
            chk($sformatf("u%0d.data_out@%0t", i, $time), o_d, 32'(e_d));
            chk($sformatf("u%0d.count@%0t", i, $time), o_c, 32'(sz));
            chk($sformatf("u%0d.full@%0t", i, $time), 32'(o_f), 32'(sz == DEP[i]));
            chk($sformatf("u%0d.empty@%0t", i, $time), 32'(o_e), 32'(sz == 0));
            chk($sformatf("u%0d.almost_full@%0t", i, $time), 32'(o_af), 32'(sz >= AFL[i]));
            chk($sformatf("u%0d.almost_empty@%0t", i, $time), 32'(o_ae), 32'(sz <= AEL[i]));
            chk($sformatf("u%0d.overflow@%0t", i, $time), 32'(o_ov), 32'(movf[i]));
            chk($sformatf("u%0d.underflow@%0t", i, $time), 32'(o_un), 32'(munf[i]));
        end
    endtask

    // Drive at the falling edge, model the rising edge, check 1 time unit later.
    task automatic step(input bit p, input bit q, input logic [7:0] d, input bit c);
        @(negedge clk);
        push = p; pop = q; data_in = d; clr = c;
        @(posedge clk);
        model_clock();
        #1;
        check_all();
    endtask

    task automatic async_reset();
        @(negedge clk);
        push = 1'b1; pop = 1'b0; clr = 1'b0; data_in = 8'h99;
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b1;
        push = 1'b0;
    endtask

    initial begin
        model_reset();
        #2;
        check_all();
        @(negedge clk);
        rst = 1'b1;

        // Basic ordering
        step(1, 0, 8'h11, 0);
        step(1, 0, 8'h22, 0);
        step(1, 0, 8'h33, 0);
        repeat (3) step(0, 1, 8'h00, 0);
        step(0, 0, 8'h00, 0);

        // Fill, overflow, wrap on the depth-5 instances
        step(0, 0, 8'h00, 1);
        for (int k = 1; k <= 6; k++) step(1, 0, 8'(k), 0);
        repeat (2) step(0, 1, 8'h00, 0);
        step(1, 0, 8'h07, 0);
        step(1, 0, 8'h08, 0);
        repeat (8) step(0, 1, 8'h00, 0);

        // Simultaneous push and pop while full
        step(0, 0, 8'h00, 1);
        for (int k = 1; k <= 5; k++) step(1, 0, 8'(k), 0);
        step(1, 1, 8'hAA, 0);
        repeat (6) step(0, 1, 8'h00, 0);

        // Simultaneous push and pop while empty
        step(0, 0, 8'h00, 1);
        step(1, 1, 8'h5C, 0);
        step(0, 0, 8'h00, 0);

        // Thresholds on the depth-16 instance
        step(0, 0, 8'h00, 1);
        for (int k = 0; k < 14; k++) step(1, 0, 8'(8'h40 + k), 0);
        repeat (12) step(0, 1, 8'h00, 0);

        // clr with a concurrent push after overflow
        step(0, 0, 8'h00, 1);
        for (int k = 0; k < 7; k++) step(1, 0, 8'(8'h70 + k), 0);
        step(1, 0, 8'hEE, 1);
        step(0, 0, 8'h00, 0);

        // Randomised traffic with occasional flush
        for (int k = 0; k < 400; k++) begin
            bit p, q, c;
            p = ($urandom_range(0, 99) < ((k < 200) ? 65 : 40));
            q = ($urandom_range(0, 99) < ((k < 200) ? 40 : 65));
            c = ($urandom_range(0, 59) == 0);
            step(p, q, 8'($urandom_range(0, 255)), c);
        end

        // Reset mid-burst, then confirm restart from a clean state
        for (int k = 0; k < 4; k++) step(1, 0, 8'(8'hC0 + k), 0);
        async_reset();
        step(1, 0, 8'hB1, 0);
        step(1, 0, 8'hB2, 0);
        step(0, 1, 8'h00, 0);
        step(0, 1, 8'h00, 0);
        step(0, 1, 8'h00, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
